// File: rtl/mips_wb_pkg.sv
// Shared types and helpers for the MIPS MEM/WB sequencer: FSM states,
// access-size codes, writeback-source selection and alignment/lane helpers.
package mips_wb_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b11;

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_LOAD = 2'b01,
    WB_LUI  = 2'b10,
    WB_LINK = 2'b11
  } wb_src_e;

  function automatic wb_src_e wb_select(input logic link, input logic lui, input logic load);
    if (link) return WB_LINK;
    if (lui)  return WB_LUI;
    if (load) return WB_LOAD;
    return WB_ALU;
  endfunction

  // Size code 2'b10 is handled as a word everywhere.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offs);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return offs[0];
      default: return offs != 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] offs);
    case (size)
      SZ_BYTE: return 4'b0001 << offs;
      SZ_HALF: return offs[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/load_filter.sv
// Little-endian load lane select followed by sign or zero extension.
module load_filter
  import mips_wb_pkg::*;
#(
  parameter int NBITS = 32
) (
  input  logic [NBITS-1:0] i_rdata,
  input  logic [1:0]       i_offs,
  input  logic [1:0]       i_size,
  input  logic             i_unsigned,
  output logic [NBITS-1:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_rdata[{i_offs, 3'b000} +: 8];
  assign w_half = i_rdata[{i_offs[1], 4'b0000} +: 16];

  always_comb begin
    o_data = i_rdata;
    case (i_size)
      SZ_BYTE: o_data = {{(NBITS-8){~i_unsigned & w_byte[7]}}, w_byte};
      SZ_HALF: o_data = {{(NBITS-16){~i_unsigned & w_half[15]}}, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/wb_mem_sequencer.sv
// MEM/WB boundary sequencer: runs data-memory accesses over req/ack, stalls
// upstream while memory is busy and drives a registered register writeback.
module wb_mem_sequencer
  import mips_wb_pkg::*;
#(
  parameter int NBITS       = 32,
  parameter int NREG_BITS   = 5,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_valid,
  input  logic                 i_load,
  input  logic                 i_store,
  input  logic                 i_lui,
  input  logic                 i_link,
  input  logic                 i_reg_write,
  input  logic [NREG_BITS-1:0] i_rd,
  input  logic [NBITS-1:0]     i_alu_result,
  input  logic [NBITS-1:0]     i_extension,
  input  logic [NBITS-1:0]     i_pc8,
  input  logic [NBITS-1:0]     i_store_data,
  input  logic [1:0]           i_mem_size,
  input  logic                 i_mem_unsigned,
  input  logic                 i_mem_ack,
  input  logic [NBITS-1:0]     i_mem_rdata,
  output logic                 o_stall,
  output logic                 o_mem_req,
  output logic                 o_mem_we,
  output logic [NBITS-1:0]     o_mem_addr,
  output logic [NBITS-1:0]     o_mem_wdata,
  output logic [3:0]           o_mem_be,
  output logic                 o_wb_en,
  output logic [NREG_BITS-1:0] o_wb_addr,
  output logic [NBITS-1:0]     o_wb_data,
  output logic                 o_misaligned,
  output logic                 o_mem_timeout
);

  localparam int               CNT_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  state_e               r_state, w_next_state;
  logic [CNT_W-1:0]     r_cnt;
  logic                 w_is_mem, w_misaligned, w_wb_write;
  logic                 w_accept, w_start_mem, w_ack_done, w_timeout_hit;
  logic [NBITS-1:0]     w_wdata, w_direct_data, w_load_data, w_mem_wb_data;

  logic                 r_mem_we;
  logic [NBITS-1:0]     r_mem_addr, r_mem_wdata;
  logic [3:0]           r_mem_be;
  logic [1:0]           r_offs, r_size;
  logic                 r_unsigned, r_wb_pending;
  wb_src_e              r_src;
  logic [NREG_BITS-1:0] r_rd;
  logic [NBITS-1:0]     r_pc8, r_ext;
  logic                 r_wb_en, r_misaligned, r_timeout;
  logic [NREG_BITS-1:0] r_wb_addr;
  logic [NBITS-1:0]     r_wb_data;

  assign w_is_mem     = i_load | i_store;
  assign w_misaligned = is_misaligned(i_mem_size, i_alu_result[1:0]);
  assign w_wb_write   = i_reg_write & ~i_store & (i_rd != '0);

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_next_state;
  end

  always_comb begin
    w_next_state  = r_state;
    w_accept      = 1'b0;
    w_start_mem   = 1'b0;
    w_ack_done    = 1'b0;
    w_timeout_hit = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_valid) begin
          w_accept = 1'b1;
          if (w_is_mem && !w_misaligned) begin
            w_start_mem  = 1'b1;
            w_next_state = MEM_WAIT;
          end
        end
      end
      MEM_WAIT: begin
        if (i_mem_ack) begin
          w_ack_done   = 1'b1;
          w_next_state = IDLE;
        end else if (r_cnt == CNT_LAST) begin
          w_timeout_hit = 1'b1;
          w_next_state  = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    w_wdata = i_store_data;
    case (i_mem_size)
      SZ_BYTE: w_wdata = {(NBITS/8){i_store_data[7:0]}};
      SZ_HALF: w_wdata = {(NBITS/16){i_store_data[15:0]}};
      default: w_wdata = i_store_data;
    endcase
  end

  // A non-memory instruction can never select the load path.
  always_comb begin
    w_direct_data = i_alu_result;
    case (wb_select(i_link, i_lui, 1'b0))
      WB_LINK: w_direct_data = i_pc8;
      WB_LUI:  w_direct_data = i_extension;
      default: w_direct_data = i_alu_result;
    endcase
  end

  always_comb begin
    w_mem_wb_data = w_load_data;
    case (r_src)
      WB_LINK: w_mem_wb_data = r_pc8;
      WB_LUI:  w_mem_wb_data = r_ext;
      default: w_mem_wb_data = w_load_data;
    endcase
  end

  load_filter #(.NBITS(NBITS)) u_load_filter (
    .i_rdata    (i_mem_rdata),
    .i_offs     (r_offs),
    .i_size     (r_size),
    .i_unsigned (r_unsigned),
    .o_data     (w_load_data)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset || w_start_mem)                      r_cnt <= '0;
    else if (r_state == MEM_WAIT && !i_mem_ack)      r_cnt <= r_cnt + 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_be     <= '0;
      r_offs       <= '0;
      r_size       <= '0;
      r_unsigned   <= 1'b0;
      r_wb_pending <= 1'b0;
      r_src        <= WB_ALU;
      r_rd         <= '0;
      r_pc8        <= '0;
      r_ext        <= '0;
    end else if (w_start_mem) begin
      r_mem_we     <= i_store;
      r_mem_addr   <= {i_alu_result[NBITS-1:2], 2'b00};
      r_mem_wdata  <= w_wdata;
      r_mem_be     <= i_store ? byte_enables(i_mem_size, i_alu_result[1:0]) : 4'b0000;
      r_offs       <= i_alu_result[1:0];
      r_size       <= i_mem_size;
      r_unsigned   <= i_mem_unsigned;
      r_wb_pending <= w_wb_write;
      r_src        <= wb_select(i_link, i_lui, i_load & ~i_store);
      r_rd         <= i_rd;
      r_pc8        <= i_pc8;
      r_ext        <= i_extension;
    end
  end

  // Writeback address/data only move when a write actually happens.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wb_en      <= 1'b0;
      r_wb_addr    <= '0;
      r_wb_data    <= '0;
      r_misaligned <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_wb_en      <= 1'b0;
      r_misaligned <= w_accept & w_is_mem & w_misaligned;
      r_timeout    <= w_timeout_hit;
      if (w_accept && !w_is_mem && w_wb_write) begin
        r_wb_en   <= 1'b1;
        r_wb_addr <= i_rd;
        r_wb_data <= w_direct_data;
      end
      if (w_ack_done && r_wb_pending) begin
        r_wb_en   <= 1'b1;
        r_wb_addr <= r_rd;
        r_wb_data <= w_mem_wb_data;
      end
    end
  end

  assign o_stall       = (r_state == MEM_WAIT);
  assign o_mem_req     = (r_state == MEM_WAIT);
  assign o_mem_we      = r_mem_we;
  assign o_mem_addr    = r_mem_addr;
  assign o_mem_wdata   = r_mem_wdata;
  assign o_mem_be      = r_mem_be;
  assign o_wb_en       = r_wb_en;
  assign o_wb_addr     = r_wb_addr;
  assign o_wb_data     = r_wb_data;
  assign o_misaligned  = r_misaligned;
  assign o_mem_timeout = r_timeout;

endmodule

// File: doc/wb_mem_sequencer.md
Name: wb_mem_sequencer

Overview:
Controls the MEM/WB boundary of the MIPS pipeline. It accepts one instruction at a time from EX/MEM, runs data-memory reads and writes over a req/ack handshake, and stalls upstream while memory is busy. It filters load data by size and sign, then drives a registered register-file writeback. The writeback value comes from one of four sources: link, LUI immediate, filtered load, or ALU result.

Parameters:
NBITS, 32, datapath width
NREG_BITS, 5, register address width
MEM_TIMEOUT, 16, max cycles waiting for i_mem_ack before abort (>=1)

Ports:
i_clk  in  1  clock
i_reset  in  1  synchronous, active-high reset
i_valid  in  1  EX/MEM holds a valid instruction
i_load  in  1  instruction is a load
i_store  in  1  instruction is a store
i_lui  in  1  instruction is LUI
i_link  in  1  instruction is JAL/JALR (write PC+8)
i_reg_write  in  1  instruction writes a register
i_rd  in  NREG_BITS  destination register
i_alu_result  in  NBITS  ALU result / memory address
i_extension  in  NBITS  immediate already shifted for LUI
i_pc8  in  NBITS  return address
i_store_data  in  NBITS  store data (rt)
i_mem_size  in  2  00 byte, 01 half, 11 word (10 treated as word)
i_mem_unsigned  in  1  zero-extend the load when 1
i_mem_ack  in  1  memory completed the access
i_mem_rdata  in  NBITS  raw read word
o_stall  out  1  upstream must hold EX/MEM
o_mem_req  out  1  memory request
o_mem_we  out  1  write enable
o_mem_addr  out  NBITS  word-aligned address ({addr[31:2],2'b00})
o_mem_wdata  out  NBITS  store data replicated across lanes
o_mem_be  out  4  byte enables
o_wb_en  out  1  register-file write strobe
o_wb_addr  out  NREG_BITS  writeback register
o_wb_data  out  NBITS  writeback value
o_misaligned  out  1  one-cycle pulse on misaligned access
o_mem_timeout  out  1  one-cycle pulse on ack timeout

Behaviour:
- Reset value of every output is 0. Reset forces state IDLE and clears the timeout counter.
- Reset mid-MEM_WAIT drops the request with no writeback, and a late ack is ignored.
- States:
  - IDLE: accepts when i_valid=1.
  - MEM_WAIT: o_mem_req=1, o_stall=1, i_valid ignored.
- o_stall = (state==MEM_WAIT), combinational from state.
- Misalignment: half access with addr[0]=1, or word access with addr[1:0]!=0.
- Accept of a load/store in IDLE:
  - Misaligned: pulse o_misaligned next cycle; no request and no writeback.
  - Otherwise: capture all fields and go to MEM_WAIT. o_mem_req, o_mem_we (=store), address, wdata and BE are registered and valid from the next cycle. The counter loads 0.
- MEM_WAIT:
  - i_mem_ack=1 → IDLE. A load captures filtered rdata. Writeback appears the cycle after ack. o_mem_req drops the cycle after ack.
  - No ack → counter increments. When the counter reaches MEM_TIMEOUT-1 without ack, go to IDLE, pulse o_mem_timeout the next cycle, and skip the writeback.
- Non-memory accept in IDLE: stays IDLE; writeback is registered with 1-cycle latency, allowing back-to-back throughput.
- o_wb_en=1 for one cycle when i_reg_write=1, i_store=0 and rd!=0. When o_wb_en=0, o_wb_addr/o_wb_data hold their last values.
- Writeback source priority: link > lui > load > alu.
- Byte enables:
  - byte: 1<<addr[1:0]
  - half: 0011 or 1100 by addr[1]
  - word: 1111
- Store data replication: byte {4{b}}, half {2{h}}, word as-is.
- Load filter (little-endian): select the lane by addr[1:0], then sign- or zero-extend per i_mem_unsigned.
- i_load and i_store both 1 is illegal; treat as store.

Decomposition:
- Package mips_wb_pkg:
  - state encoding (IDLE, MEM_WAIT)
  - size codes (SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b11)
  - writeback-source codes (ALU, LOAD, LUI, LINK)
- One sub-module, load_filter: combinational lane select plus extension (rdata, addr[1:0], size, unsigned → NBITS).

Test Plan:
- ALU op: rd=5, alu=0x0000_1234 → next cycle o_wb_en=1, o_wb_addr=5, o_wb_data=0x1234, o_stall never 1.
- LUI with ext=0xABCD_0000, alu=0x1 → o_wb_data=0xABCD_0000; link=1, pc8=0x40 together with lui → o_wb_data=0x40.
- Signed byte load, addr=0x103:
  - request: o_mem_addr=0x100, o_mem_be=0000 (we=0); ack after 3 cycles, rdata=0x80FF_FF7F, unsigned=0.
  - required: o_stall high 4 cycles, o_wb_data=0xFFFF_FF80; with unsigned=1 → 0x0000_0080.
- Half store, addr=0x22, data=0x0000_BEEF → o_mem_we=1, o_mem_be=1100, o_mem_wdata=0xBEEF_BEEF, no o_wb_en.
- Word load, addr=0x101 → o_misaligned pulse, o_mem_req stays 0, no writeback.
- No ack, MEM_TIMEOUT=4 → o_mem_timeout after 4 wait cycles, stall released, no writeback. Separately, i_reset asserted mid-wait → all outputs 0 next cycle.
